mem_arbiter: RTL and testbench

- Sequences the single shared, pipelined main memory between the I-cache miss path and the D-cache miss/write-through path of the pipelined CPU.
- Grants one requester at a time and issues the block-fill address stream or a single write-through word.
- Steers returning read data back to the granted cache with a word index, and signals completion.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss paths for one shared pipelined memory.
// Issues block-fill read streams or single write-through words and steers read data back.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             i_miss_i,
  input  logic [ADDR_W-1:0]                i_addr_i,
  input  logic                             d_miss_i,
  input  logic                             d_wr_i,
  input  logic [ADDR_W-1:0]                d_addr_i,
  input  logic [DATA_W-1:0]                d_wdata_i,
  output logic [DATA_W-1:0]                fill_data_o,
  output logic                             i_fill_valid_o,
  output logic                             d_fill_valid_o,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_idx_o,
  output logic                             i_fill_done_o,
  output logic                             d_fill_done_o,
  output logic                             d_wr_done_o,
  output logic                             mem_en_o,
  output logic                             mem_wr_o,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic [DATA_W-1:0]                mem_wdata_o,
  input  logic [DATA_W-1:0]                mem_rdata_i,
  input  logic                             mem_rvalid_i,
  output logic                             busy_o
);

  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam int DRN_W = $clog2(MEM_LAT + 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [2:0] {DRAIN, IDLE, I_FILL, D_FILL, D_WRITE} state_e;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drainCnt_q, drainCnt_d;
  logic [IDX_W-1:0]   issueCnt_q, issueCnt_d;
  logic [IDX_W-1:0]   retCnt_q, retCnt_d;
  logic               issueDone_q, issueDone_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DRAIN;
      drainCnt_q  <= DRN_W'(MEM_LAT);
      issueCnt_q  <= '0;
      retCnt_q    <= '0;
      issueDone_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      drainCnt_q  <= drainCnt_d;
      issueCnt_q  <= issueCnt_d;
      retCnt_q    <= retCnt_d;
      issueDone_q <= issueDone_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drainCnt_d     = drainCnt_q;
    issueCnt_d     = issueCnt_q;
    retCnt_d       = retCnt_q;
    issueDone_d    = issueDone_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    fill_data_o    = '0;
    i_fill_valid_o = 1'b0;
    d_fill_valid_o = 1'b0;
    fill_idx_o     = '0;
    i_fill_done_o  = 1'b0;
    d_fill_done_o  = 1'b0;
    d_wr_done_o    = 1'b0;
    mem_en_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    busy_o         = (state_q != IDLE);

    case (state_q)
      // Reads issued before reset may still return; wait them out before granting.
      DRAIN: begin
        if (drainCnt_q <= DRN_W'(1)) state_d = IDLE;
        else                         drainCnt_d = drainCnt_q - 1'b1;
      end
      IDLE: begin
        issueCnt_d  = '0;
        retCnt_d    = '0;
        issueDone_d = 1'b0;
        if (d_miss_i && d_wr_i) begin
          state_d = D_WRITE;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
        end else if (d_miss_i) begin
          state_d = D_FILL;
          addr_d  = d_addr_i & BLK_MASK;
        end else if (i_miss_i) begin
          state_d = I_FILL;
          addr_d  = i_addr_i & BLK_MASK;
        end
      end
      I_FILL, D_FILL: begin
        if (!issueDone_q) begin
          mem_en_o    = 1'b1;
          mem_addr_o  = addr_q + (ADDR_W'(issueCnt_q) << 1);
          issueCnt_d  = issueCnt_q + 1'b1;
          issueDone_d = (issueCnt_q == LAST_IDX);
        end
        // Memory returns in issue order, so a plain return counter gives the word index.
        if (mem_rvalid_i) begin
          fill_data_o    = mem_rdata_i;
          fill_idx_o     = retCnt_q;
          i_fill_valid_o = (state_q == I_FILL);
          d_fill_valid_o = (state_q == D_FILL);
          retCnt_d       = retCnt_q + 1'b1;
          if (retCnt_q == LAST_IDX) begin
            i_fill_done_o = (state_q == I_FILL);
            d_fill_done_o = (state_q == D_FILL);
            state_d       = IDLE;
          end
        end
      end
      D_WRITE: begin
        mem_en_o    = 1'b1;
        mem_wr_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        d_wr_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = DRAIN;
    endcase

    if (rst_i) begin
      fill_data_o    = '0;
      i_fill_valid_o = 1'b0;
      d_fill_valid_o = 1'b0;
      fill_idx_o     = '0;
      i_fill_done_o  = 1'b0;
      d_fill_done_o  = 1'b0;
      d_wr_done_o    = 1'b0;
      mem_en_o       = 1'b0;
      mem_wr_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      busy_o         = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-4 memory model plus scoreboard queues of expected
// memory issues and fill words, driven from a table of grant vectors and corner sequences.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        iMiss, dMiss, dWr;
  logic [15:0] iAddr, dAddr, dWdata;
  logic [15:0] fillData;
  logic        iFillValid, dFillValid;
  logic [2:0]  fillIdx;
  logic        iFillDone, dFillDone, dWrDone;
  logic        memEn, memWr;
  logic [15:0] memAddr, memWdata, memRdata;
  logic        memRvalid;
  logic        busy;
  logic [15:0] memTag;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } issue_t;

  typedef struct {
    logic        isI;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } fill_t;

  // kind: 0 = I fill, 1 = D fill, 2 = write-through
  typedef struct {
    logic        iMiss;
    logic        dMiss;
    logic        dWr;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] altDAddr;
    logic [15:0] wdata;
    logic [15:0] tag;
    logic [1:0]  expKind;
    logic [15:0] expBase;
  } vec_t;

  issue_t issueQ[$];
  fill_t  fillQ[$];
  vec_t   vecs[7];

  mem_arbiter dut (
    .clk_i(clock), .rst_i(reset),
    .i_miss_i(iMiss), .i_addr_i(iAddr),
    .d_miss_i(dMiss), .d_wr_i(dWr), .d_addr_i(dAddr), .d_wdata_i(dWdata),
    .fill_data_o(fillData), .i_fill_valid_o(iFillValid), .d_fill_valid_o(dFillValid),
    .fill_idx_o(fillIdx), .i_fill_done_o(iFillDone), .d_fill_done_o(dFillDone),
    .d_wr_done_o(dWrDone), .mem_en_o(memEn), .mem_wr_o(memWr), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .mem_rvalid_i(memRvalid), .busy_o(busy)
  );

  always #5 clock = ~clock;

  // Pipelined memory: a read issued in cycle c returns in cycle c+MEM_LAT with tag + word index.
  logic [MEM_LAT-1:0] pipeV;
  logic [15:0]        pipeD [MEM_LAT];
  always @(posedge clock) begin
    pipeV    <= {pipeV[MEM_LAT-2:0], memEn & ~memWr};
    pipeD[0] <= memTag + ((memAddr >> 1) & 16'h0007);
    for (int k = 1; k < MEM_LAT; k++) pipeD[k] <= pipeD[k-1];
  end
  assign memRvalid = pipeV[MEM_LAT-1];
  assign memRdata  = pipeD[MEM_LAT-1];

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every memory issue and every returned fill word is popped and compared.
  always @(negedge clock) begin
    issue_t iss;
    fill_t  fw;
    if (memEn) begin
      if (issueQ.size() == 0) checkOutput("mem_en unexpected", memEn, 0);
      else begin
        iss = issueQ.pop_front();
        checkOutput("mem_wr", memWr, iss.wr);
        checkOutput("mem_addr", memAddr, iss.addr);
        checkOutput("mem_wdata", memWdata, iss.wdata);
        checkOutput("d_wr_done", dWrDone, iss.wr);
      end
    end else if (dWrDone) checkOutput("d_wr_done stray", dWrDone, 0);

    if (iFillValid || dFillValid) begin
      if (fillQ.size() == 0) checkOutput("fill_valid unexpected", {iFillValid, dFillValid}, 0);
      else begin
        fw = fillQ.pop_front();
        checkOutput("valid route", {iFillValid, dFillValid}, {fw.isI, ~fw.isI});
        checkOutput("fill_idx", fillIdx, fw.idx);
        checkOutput("fill_data", fillData, fw.data);
        checkOutput("fill_done", {iFillDone, dFillDone}, {fw.isI & fw.last, ~fw.isI & fw.last});
      end
    end else if (iFillDone || dFillDone) checkOutput("done stray", {iFillDone, dFillDone}, 0);
  end

  task automatic pushFill(input logic isI, input logic [15:0] base, input logic [15:0] tag);
    for (int k = 0; k < 8; k++) begin
      issueQ.push_back('{1'b0, base + 16'(2 * k), 16'h0000});
      fillQ.push_back('{isI, 3'(k), tag + 16'(k), k == 7});
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idle before grant", busy, 0);
    @(posedge clock); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   n;
    logic doneSeen = 1'b0;
    waitIdle();
    memTag = v.tag;
    if (v.expKind == 2) issueQ.push_back('{1'b1, v.expBase, v.wdata});
    else                pushFill(v.expKind == 0, v.expBase, v.tag);
    iMiss = v.iMiss; dMiss = v.dMiss; dWr = v.dWr;
    iAddr = v.iAddr; dAddr = v.dAddr; dWdata = v.wdata;
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 3) dAddr = v.altDAddr;
      doneSeen = (v.expKind == 2) ? dWrDone : (v.expKind == 0) ? iFillDone : dFillDone;
      if (doneSeen) break;
    end
    checkOutput("done seen", doneSeen, 1);
    checkOutput("grant to done cycles", n - 1, (v.expKind == 2) ? 1 : 12);
    @(posedge clock); #1;
    iMiss = 0; dMiss = 0; dWr = 0;
    @(negedge clock);
    checkOutput("busy after done", busy, 0);
    checkOutput("queues drained", issueQ.size() + fillQ.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1; iMiss = 0; dMiss = 0; dWr = 0;
    iAddr = 0; dAddr = 0; dWdata = 0; memTag = 0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1236, 16'h0000, 16'h0000, 16'h0000, 16'hA000, 2'd0, 16'h1230};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0047, 16'h0047, 16'h0000, 16'hD000, 2'd1, 16'h0040};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0102, 16'h0102, 16'hBEEF, 16'h0000, 2'd2, 16'h0102};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h1110, 2'd0, 16'hFFF0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h800F, 16'h800F, 16'h0000, 16'h5550, 2'd1, 16'h8000};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 2'd2, 16'hFFFF};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0300, 16'h0000, 16'h2200, 2'd1, 16'h0200};

    // Reset, then exactly MEM_LAT busy drain cycles.
    repeat (2) begin
      @(negedge clock);
      checkOutput("busy in reset", busy, 1);
      checkOutput("mem_en in reset", memEn, 0);
    end
    @(posedge clock); #1;
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("drain busy", busy, (k < 4) ? 1 : 0);
    end

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Simultaneous requests: D fill first, I fill granted in the first IDLE cycle after.
    waitIdle();
    memTag = 16'h3000;
    pushFill(1'b0, 16'h0040, 16'h3000);
    iMiss = 1; iAddr = 16'h0456; dMiss = 1; dWr = 0; dAddr = 16'h0040;
    for (n = 1; n <= 40 && !dFillDone; n++) @(negedge clock);
    checkOutput("simul d done", dFillDone, 1);
    @(posedge clock); #1;
    dMiss = 0;
    memTag = 16'h4000;
    pushFill(1'b1, 16'h0450, 16'h4000);
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (iFillDone) break;
    end
    checkOutput("simul i done", iFillDone, 1);
    checkOutput("simul i grant to done", n - 1, 12);
    @(posedge clock); #1;
    iMiss = 0;
    @(negedge clock);
    checkOutput("simul busy after", busy, 0);

    // Reset after three issues: no done, stale returns during drain are dropped.
    waitIdle();
    memTag = 16'h6000;
    for (int k = 0; k < 3; k++) issueQ.push_back('{1'b0, 16'h0700 + 16'(2 * k), 16'h0000});
    iMiss = 1; iAddr = 16'h0700;
    repeat (4) begin
      @(posedge clock); #1;
    end
    reset = 1; iMiss = 0;
    @(negedge clock);
    checkOutput("abort mem_en", memEn, 0);
    @(posedge clock); #1;
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("stale i_fill_valid", iFillValid, 0);
      checkOutput("stale i_fill_done", iFillDone, 0);
      checkOutput("stale busy", busy, 1);
    end
    checkOutput("abort issue queue", issueQ.size(), 0);
    applyStimulus('{1'b1, 1'b0, 1'b0, 16'h0700, 16'h0000, 16'h0000, 16'h0000, 16'h7000, 2'd0, 16'h0700});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
